// File: rtl/ppu_pkg.sv
// ============================================================================
// ppu_pkg : shared types and constants for the opsum post-processing unit
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package ppu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FLUSH = 2'd3
    } ppu_state_e;

    localparam int         QMIN       = -128;
    localparam int         QMAX       = 127;
    localparam logic [7:0] ZERO_POINT = 8'h80;
    localparam int         LANES      = 4;

endpackage

`default_nettype wire

// File: rtl/ppu_requant.sv
// ============================================================================
// ppu_requant : two-stage round/shift then clamp/zero-point pipeline.
// ReLU before the clamp exists only when PPU_RELU_EN is defined.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module ppu_requant
    import ppu_pkg::*;
#(
    parameter int DATA_BITS = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en_i,
    input  logic                 valid_i,
    input  logic [DATA_BITS-1:0] psum_i,
    input  logic [4:0]           shift_i,
    input  logic                 relu_i,
    output logic                 valid_o,
    output logic [7:0]           byte_o
);

    localparam int SW = DATA_BITS + 1;
    localparam logic signed [SW-1:0] LO = SW'(QMIN);
    localparam logic signed [SW-1:0] HI = SW'(QMAX);

    logic signed [SW-1:0] w_ext, w_rnd, w_sum, w_r, w_rr;
    logic        [7:0]    w_cl;
    logic signed [SW-1:0] r_q;
    logic                 r_valid_q;
    logic        [7:0]    byte_q;
    logic                 byte_valid_q;

    // One guard bit keeps psum + rounding constant from wrapping.
    assign w_ext = {psum_i[DATA_BITS-1], psum_i};
    assign w_rnd = (shift_i != 5'd0) ? (SW'(1) << (shift_i - 5'd1)) : '0;
    assign w_sum = w_ext + w_rnd;
    assign w_r   = w_sum >>> shift_i;

`ifdef PPU_RELU_EN
    assign w_rr = (relu_i && (r_q < 0)) ? '0 : r_q;
`else
    logic unused_relu;
    assign unused_relu = relu_i;
    assign w_rr        = r_q;
`endif

    always_comb begin
        w_cl = w_rr[7:0];
        if (w_rr < LO) begin
            w_cl = LO[7:0];
        end else if (w_rr > HI) begin
            w_cl = HI[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q          <= '0;
            r_valid_q    <= 1'b0;
            byte_q       <= '0;
            byte_valid_q <= 1'b0;
        end else if (en_i) begin
            r_valid_q    <= valid_i;
            byte_valid_q <= r_valid_q;
            if (valid_i) begin
                r_q <= w_r;
            end
            if (r_valid_q) begin
                byte_q <= w_cl ^ ZERO_POINT;
            end
        end
    end

    assign valid_o = byte_valid_q;
    assign byte_o  = byte_q;

endmodule

`default_nettype wire

// File: rtl/opsum_ppu.sv
// ============================================================================
// opsum_ppu : requantizes a tile of signed psums into packed uint8 words.
// Optional ReLU is enabled by defining PPU_RELU_EN.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module opsum_ppu
    import ppu_pkg::*;
#(
    parameter int DATA_BITS = 32,
    parameter int LEN_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [LEN_BITS-1:0]  cfg_len,
    input  logic [4:0]           cfg_shift,
    input  logic                 cfg_relu,
    input  logic [DATA_BITS-1:0] psum_in,
    input  logic                 psum_valid,
    output logic                 psum_ready,
    output logic [DATA_BITS-1:0] ofmap_out,
    output logic                 ofmap_valid,
    input  logic                 ofmap_ready,
    output logic                 ofmap_last,
    output logic                 busy,
    output logic                 done
);

    ppu_state_e           state_q;
    logic [LEN_BITS-1:0]  len_q, acc_q, pk_q;
    logic [4:0]           shift_q;
    logic                 relu_q;
    logic [DATA_BITS-1:0] pack_q, out_q;
    logic [1:0]           lane_q;
    logic                 full_q, plast_q, ovalid_q, olast_q, done_q;

    logic                 w_stall, w_take, w_byte_v, w_final, w_acc_last;
    logic [7:0]           w_byte;
    logic [LEN_BITS-1:0]  w_acc_next, w_pk_next;
    logic [1:0]           w_lane;
    logic [DATA_BITS-1:0] w_word_d;

    assign w_stall    = ovalid_q && !ofmap_ready;
    assign psum_ready = (state_q == ST_RUN) && !w_stall && (acc_q < len_q);
    assign w_take     = psum_ready && psum_valid;
    assign w_acc_next = acc_q + 1'b1;
    assign w_pk_next  = pk_q + 1'b1;
    assign w_acc_last = (w_acc_next == len_q);
    assign w_final    = (w_pk_next == len_q);

`ifdef PPU_RELU_EN
    logic w_relu_d;
    assign w_relu_d = cfg_relu;
`else
    logic unused_cfg_relu;
    logic w_relu_d;
    assign unused_cfg_relu = cfg_relu;
    assign w_relu_d        = 1'b0;
`endif

    ppu_requant #(
        .DATA_BITS (DATA_BITS)
    ) u_requant (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (!w_stall),
        .valid_i (w_take),
        .psum_i  (psum_in),
        .shift_i (shift_q),
        .relu_i  (relu_q),
        .valid_o (w_byte_v),
        .byte_o  (w_byte)
    );

    // A full buffer is handed to the output register this cycle, so the
    // incoming byte starts a fresh zero-padded word in lane 0.
    assign w_lane = full_q ? 2'd0 : lane_q;
    always_comb begin
        w_word_d = full_q ? '0 : pack_q;
        w_word_d[{w_lane, 3'b000} +: 8] = w_byte;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            len_q    <= '0;
            shift_q  <= '0;
            relu_q   <= 1'b0;
            acc_q    <= '0;
            pk_q     <= '0;
            pack_q   <= '0;
            lane_q   <= '0;
            full_q   <= 1'b0;
            plast_q  <= 1'b0;
            out_q    <= '0;
            ovalid_q <= 1'b0;
            olast_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (!w_stall) begin
                if (full_q) begin
                    out_q    <= pack_q;
                    ovalid_q <= 1'b1;
                    olast_q  <= plast_q;
                end else if (ovalid_q) begin
                    ovalid_q <= 1'b0;
                    olast_q  <= 1'b0;
                end
                if (w_byte_v) begin
                    pack_q  <= w_word_d;
                    lane_q  <= w_lane + 2'd1;
                    full_q  <= (w_lane == 2'(LANES - 1)) || w_final;
                    plast_q <= w_final;
                    pk_q    <= w_pk_next;
                end else if (full_q) begin
                    pack_q  <= '0;
                    lane_q  <= '0;
                    full_q  <= 1'b0;
                    plast_q <= 1'b0;
                end
                if (w_take) begin
                    acc_q <= w_acc_next;
                end
            end
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        len_q   <= cfg_len;
                        shift_q <= cfg_shift;
                        relu_q  <= w_relu_d;
                        acc_q   <= '0;
                        pk_q    <= '0;
                        state_q <= (cfg_len == '0) ? ST_FLUSH : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_take && w_acc_last) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!w_stall && w_byte_v && w_final) begin
                        state_q <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (!full_q && (!ovalid_q || ofmap_ready)) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ofmap_out   = out_q;
    assign ofmap_valid = ovalid_q;
    assign ofmap_last  = olast_q;
    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;

endmodule

`default_nettype wire

// File: tb/tb_opsum_ppu.sv
// ============================================================================
// tb_opsum_ppu : directed self-checking bench for opsum_ppu
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_opsum_ppu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  cfg_len = '0;
    logic [4:0]  cfg_shift = '0;
    logic        cfg_relu = 1'b0;
    logic [31:0] psum_in = '0;
    logic        psum_valid = 1'b0;
    logic        psum_ready;
    logic [31:0] ofmap_out;
    logic        ofmap_valid;
    logic        ofmap_ready = 1'b1;
    logic        ofmap_last;
    logic        busy;
    logic        done;

    int          n_cmp = 0;
    int          n_err = 0;
    int          vcount = 0;
    logic [32:0] q[$];
    logic [31:0] vec[8];

    opsum_ppu #(.DATA_BITS(32), .LEN_BITS(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .cfg_len     (cfg_len),
        .cfg_shift   (cfg_shift),
        .cfg_relu    (cfg_relu),
        .psum_in     (psum_in),
        .psum_valid  (psum_valid),
        .psum_ready  (psum_ready),
        .ofmap_out   (ofmap_out),
        .ofmap_valid (ofmap_valid),
        .ofmap_ready (ofmap_ready),
        .ofmap_last  (ofmap_last),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ofmap_valid) vcount++;
        if (ofmap_valid && ofmap_ready) q.push_back({ofmap_last, ofmap_out});
    end

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_tile(input logic [7:0] len, input logic [4:0] sh, input logic relu);
        @(posedge clk); #1;
        cfg_len = len; cfg_shift = sh; cfg_relu = relu; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic feed(input int n);
        int g;
        for (int i = 0; i < n; i++) begin
            psum_in = vec[i];
            psum_valid = 1'b1;
            @(negedge clk);
            g = 0;
            while (!psum_ready && g < 200) begin
                @(negedge clk);
                g++;
            end
            if (g >= 200) check("feed_ready", {63'd0, psum_ready}, 64'd1);
            @(posedge clk); #1;
        end
        psum_valid = 1'b0;
        psum_in = '0;
    endtask

    task automatic wait_done(input string tag);
        int g;
        g = 0;
        @(negedge clk);
        while (!done && g < 300) begin
            @(negedge clk);
            g++;
        end
        check(tag, {63'd0, done}, 64'd1);
    endtask

    initial begin
        longint t0;
        int     v0;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_psum_ready", {63'd0, psum_ready}, 64'd0);
        check("rst_ofmap_valid", {63'd0, ofmap_valid}, 64'd0);
        check("rst_ofmap_last", {63'd0, ofmap_last}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_ofmap_out", {32'd0, ofmap_out}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // shift 4, psum 100 -> 0x86, valid 3 cycles after handshake
        q.delete();
        vec[0] = 32'd100;
        start_tile(8'd1, 5'd4, 1'b0);
        feed(1);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("lat_valid_early", {63'd0, ofmap_valid}, 64'd0);
        @(negedge clk);
        check("lat_valid", {63'd0, ofmap_valid}, 64'd1);
        check("s4_word", {32'd0, ofmap_out}, 64'h86);
        check("s4_last", {63'd0, ofmap_last}, 64'd1);
        wait_done("s4_done");

        // saturation both ways and negative rounding
        q.delete();
        vec[0] = -32'sd1000; vec[1] = 32'd1000; vec[2] = -32'sd3;
        start_tile(8'd3, 5'd2, 1'b0);
        feed(3);
        wait_done("sat_done");
        check("sat_count", 64'(q.size()), 64'd1);
        check("sat_word", {31'd0, q[0]}, {31'd0, 1'b1, 32'h007FFF00});

        // ReLU request on a negative psum
        q.delete();
        vec[0] = -32'sd1000;
        start_tile(8'd1, 5'd2, 1'b1);
        feed(1);
        wait_done("relu_done");
`ifdef PPU_RELU_EN
        check("relu_word", {31'd0, q[0]}, {31'd0, 1'b1, 32'h00000080});
`else
        check("relu_word", {31'd0, q[0]}, {31'd0, 1'b1, 32'h00000000});
`endif

        // shift 31 on the psum extremes needs the guard bit
        q.delete();
        vec[0] = 32'h7FFF_FFFF; vec[1] = 32'h8000_0000;
        start_tile(8'd2, 5'd31, 1'b0);
        feed(2);
        wait_done("s31_done");
        check("s31_word", {31'd0, q[0]}, {31'd0, 1'b1, 32'h00007F81});

        // six psums, two words, restart ignored while busy, full rate
        q.delete();
        for (int i = 0; i < 6; i++) vec[i] = 32'(i);
        start_tile(8'd6, 5'd0, 1'b0);
        cfg_len = 8'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t0 = $time;
        feed(6);
        check("rate_time", 64'($time - t0), 64'd60);
        wait_done("len6_done");
        check("len6_count", 64'(q.size()), 64'd2);
        check("len6_word0", {31'd0, q[0]}, {31'd0, 1'b0, 32'h83828180});
        check("len6_word1", {31'd0, q[1]}, {31'd0, 1'b1, 32'h00008584});
        @(negedge clk);
        check("len6_done_width", {63'd0, done}, 64'd0);

        // ten-cycle backpressure mid-tile
        q.delete();
        for (int i = 0; i < 8; i++) vec[i] = 32'(10 + i);
        ofmap_ready = 1'b0;
        start_tile(8'd8, 5'd0, 1'b0);
        fork
            feed(8);
        join_none
        begin
            int g;
            g = 0;
            @(negedge clk);
            while (!ofmap_valid && g < 100) begin
                @(negedge clk);
                g++;
            end
        end
        for (int i = 0; i < 10; i++) begin
            check("stall_out", {32'd0, ofmap_out}, 64'h8D8C8B8A);
            check("stall_psum_ready", {63'd0, psum_ready}, 64'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        ofmap_ready = 1'b1;
        wait_done("stall_done");
        wait fork;
        check("stall_count", 64'(q.size()), 64'd2);
        check("stall_word0", {31'd0, q[0]}, {31'd0, 1'b0, 32'h8D8C8B8A});
        check("stall_word1", {31'd0, q[1]}, {31'd0, 1'b1, 32'h91908F8E});

        // empty tile
        @(posedge clk); #1;
        v0 = vcount;
        start_tile(8'd0, 5'd0, 1'b0);
        @(negedge clk);
        check("len0_busy", {63'd0, busy}, 64'd1);
        check("len0_done_early", {63'd0, done}, 64'd0);
        @(negedge clk);
        check("len0_done", {63'd0, done}, 64'd1);
        check("len0_idle", {63'd0, busy}, 64'd0);
        @(posedge clk); #1;
        check("len0_no_valid", 64'(vcount - v0), 64'd0);

        // reset while running, then a clean four-psum tile
        q.delete();
        vec[0] = 32'd7; vec[1] = 32'd9;
        start_tile(8'd4, 5'd0, 1'b0);
        feed(2);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", {63'd0, busy}, 64'd0);
        check("mid_rst_valid", {63'd0, ofmap_valid}, 64'd0);
        check("mid_rst_ready", {63'd0, psum_ready}, 64'd0);
        check("mid_rst_out", {32'd0, ofmap_out}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        v0 = vcount;
        repeat (8) @(posedge clk);
        #1;
        check("post_rst_no_valid", 64'(vcount - v0), 64'd0);
        check("post_rst_no_word", 64'(q.size()), 64'd0);
        for (int i = 0; i < 4; i++) vec[i] = 32'(i + 1);
        start_tile(8'd4, 5'd0, 1'b0);
        feed(4);
        wait_done("post_rst_done");
        check("post_rst_count", 64'(q.size()), 64'd1);
        check("post_rst_word", {31'd0, q[0]}, {31'd0, 1'b1, 32'h84838281});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
